fx_mul_scale: RTL and testbench
===============================

Name: fx_mul_scale

Overview:
- Parametrised signed fixed-point multiplier with decimal rescale: out = (a*b)/SCALE, truncated toward zero, then saturated or wrapped to W bits.
- Generalises the fixed 16-bit, divide-by-100 combinational multiply used by the transform/projection datapath.
- Adds a valid/ready handshake, an iterative divider (no combinational `/`), and an overflow flag.
- Sits between the rotation-matrix coefficient stage and the perspective-projection stage.

Parameters:
- W, 16, operand and result width (signed two's complement), W >= 4
- SCALE, 100, rescale divisor, 1 <= SCALE < 2^(2W-1)
- SAT, 1, 1 = saturate result on overflow; 0 = keep low W bits of quotient (wrap)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair
- in_a  input  W  signed multiplicand
- in_b  input  W  signed multiplier
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_p  output  W  signed scaled product
- out_ovf  output  1  quotient outside [-2^(W-1), 2^(W-1)-1]; set regardless of SAT

Behaviour:
- Reset, asynchronous, any state:
  - state=IDLE, out_valid=0, out_p=0, out_ovf=0, divider counter=0.
  - in_ready=0 while rst is high.
  - An operation in flight is discarded; no output is produced for it.
- States: IDLE -> MUL -> DIV -> FIX -> DONE -> IDLE.
- IDLE:
  - in_ready = 1 (combinational from state, gated by !rst).
  - Accept on in_valid && in_ready at edge E0: latch a, b; go to MUL.
- MUL (E1):
  - Register the full 2W-bit signed product.
  - Record result sign = sign(a) XOR sign(b), forced positive when the product is 0.
  - Register |product| as 2W-bit unsigned; go to DIV with counter = 2W.
- DIV:
  - Restoring unsigned division of |product| by SCALE, one quotient bit per edge, MSB first.
  - Runs edges E2..E(2W+1); when counter reaches 0, go to FIX.
  - Remainder is discarded.
- FIX (E2W+2):
  - Apply sign to the quotient (this gives truncation toward zero).
  - Compute ovf.
  - If SAT=1 and ovf: out_p = +max or -min per sign. Otherwise out_p = low W bits of the signed quotient.
  - Set out_valid=1 and go to DONE.
- Latency: out_valid is first high after edge E(2W+2), i.e. 34 cycles after the accept edge for W=16. Latency is fixed and independent of data.
- DONE:
  - out_p and out_ovf are held stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid=0, go to IDLE.
  - in_ready rises the cycle after the handoff; no same-cycle re-accept.
- Single outstanding operation. in_valid and operand changes are ignored outside IDLE.
- SCALE=1 degenerates to a plain saturating/wrapping multiply with the same latency.
- Zero operand -> out_p=0, out_ovf=0.
- SCALE is a constant; no divide-by-zero path exists.

Decomposition:
- Shared package fx_pkg holds:
  - the state enum (IDLE, MUL, DIV, FIX, DONE);
  - default width constant FX_W=16;
  - default scale constant FX_SCALE=100;
  - saturation limit functions fx_max(W) and fx_min(W).
- One natural sub-module: udiv_iter, a parametrised iterative unsigned restoring divider.
  - Parameters: N = 2W.
  - Ports: start, dividend, divisor, busy, done, quotient.
  - fx_mul_scale owns the sign handling, the saturation logic and the handshake.

Test Plan:
- W=16, SCALE=100, SAT=1: a=-9306, b=99 -> out_p=-9212, out_ovf=0; out_valid exactly 34 cycles after accept.
- W=16, SAT=1: a=32767, b=32767 -> out_p=32767, out_ovf=1. a=-32768, b=32767 -> out_p=-32768, out_ovf=1.
- W=16, SAT=0: a=32767, b=32767 -> quotient 10736762 -> out_p=-11142 (0xD47A), out_ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_p and out_valid stable, in_ready=0. Then pulse out_ready -> in_ready high the next cycle. Back-to-back ops (a=150, b=-7 -> -10; a=0, b=-5 -> 0) complete in order.
- Reset mid-DIV: assert rst 10 cycles after accept -> out_valid=0 immediately. After release, in_ready=1 and the next op a=200, b=300 -> 600 with full latency.
- Parameter sweep: W=8, SCALE=10, SAT=1: a=-128, b=-128 -> out_p=127, out_ovf=1; a=25, b=-3 -> out_p=-7.

Source files
------------

// File: rtl/fx_pkg.sv
// Shared definitions for the fixed-point multiply/rescale block.
// Holds the sequencer state encoding, default sizing constants, and the saturation limits.
// No logic; used only through import by fx_mul_scale and its datapath.
package fx_pkg;

    // Sequencer states. Each operation walks through them in this order.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } fx_state_t;

    localparam int FX_W     = 16;
    localparam int FX_SCALE = 100;

    // Largest positive value of a w-bit two's complement number.
    function automatic longint fx_max(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    // Most negative value of a w-bit two's complement number.
    function automatic longint fx_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/udiv_iter.sv
// Iterative unsigned restoring divider: one quotient bit per clock, MSB first; remainder dropped.
// Latency: N edges after the start edge; 'done' is high during the cycle whose edge resolves the last bit.
// No backpressure: start is honoured in any state and restarts the division.
//
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   start      load dividend and begin (one-cycle pulse)
//   dividend   N-bit unsigned numerator, sampled on the start edge
//   divisor    N-bit unsigned denominator, must be nonzero and stable while busy
//   busy       division in progress
//   done       the coming edge produces the final quotient bit
//   quotient   N-bit unsigned quotient, final once busy drops
module udiv_iter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] cnt;
    logic [N-1:0]  rem_q;
    // Holds the dividend at load; dividend bits shift out of the top while
    // quotient bits shift in at the bottom, so it ends up as the quotient.
    logic [N-1:0]  quo_q;

    logic [N:0]    sh;
    logic          geq;
    logic [N-1:0]  diff;
    logic [N-1:0]  rem_nxt;

    // Partial remainder extended by the next dividend bit. It can need N+1
    // bits, but whatever gets stored back is always below the divisor.
    assign sh      = {rem_q, quo_q[N-1]};
    assign geq     = (sh >= {1'b0, divisor});
    assign diff    = sh[N-1:0] - divisor;
    assign rem_nxt = geq ? diff : sh[N-1:0];

    assign busy     = (cnt != '0);
    assign done     = (cnt == CW'(1));
    assign quotient = quo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= '0;
        end else if (start) begin
            cnt   <= CW'(N);
            rem_q <= '0;
            quo_q <= dividend;
        end else if (busy) begin
            cnt   <= cnt - CW'(1);
            rem_q <= rem_nxt;
            quo_q <= {quo_q[N-2:0], geq};
        end
    end

endmodule

// File: rtl/fx_mul_scale.sv
// Signed fixed-point multiply with decimal rescale: out = trunc0((a*b)/SCALE), saturated or wrapped to W bits.
// Latency: fixed 2W+2 edges from accept to out_valid (34 for W=16), independent of data.
// Backpressure: one operation in flight; result held while !out_ready, in_ready low until the cycle after handoff.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset (aborts any operation)
//   in_valid/in_ready    operand handshake; in_ready only in IDLE
//   in_a, in_b           signed W-bit operands
//   out_valid/out_ready  result handshake
//   out_p                signed W-bit scaled product
//   out_ovf              quotient did not fit in W bits (reported whether or not SAT is set)
module fx_mul_scale
    import fx_pkg::*;
#(
    parameter int W     = FX_W,
    parameter int SCALE = FX_SCALE,
    parameter int SAT   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_p,
    output logic         out_ovf
);

    localparam int N = 2 * W;
    localparam logic [N-1:0]        DIVISOR = N'(SCALE);
    localparam logic signed [W-1:0] P_MAX   = W'(fx_max(W));
    localparam logic signed [W-1:0] P_MIN   = W'(fx_min(W));

    fx_state_t state, state_nxt;

    logic signed [W-1:0] a_q, b_q;
    logic signed [N-1:0] prod;
    logic [N-1:0]        prod_abs;
    logic                neg_q;

    logic                div_start, div_busy, div_done;
    logic [N-1:0]        quot;
    logic signed [N-1:0] quot_s;
    logic                ovf;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // Operands sign-extended to N bits first, so the N-bit product is exact.
    assign prod     = N'(a_q) * N'(b_q);
    // |(-2^(W-1))^2| = 2^(2W-2) still fits in N unsigned bits.
    assign prod_abs = prod[N-1] ? $unsigned(-prod) : $unsigned(prod);

    // The divider loads |a*b| on the MUL edge, so its counter is 2W entering DIV.
    assign div_start = (state == MUL);

    udiv_iter #(
        .N (N)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (prod_abs),
        .divisor  (DIVISOR),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quot)
    );

    // Dividing the magnitude and re-applying the sign truncates toward zero.
    assign quot_s = neg_q ? -$signed(quot) : $signed(quot);

    // The quotient fits in W bits exactly when bits N-1..W-1 are all copies
    // of the sign bit.
    assign ovf = (|quot_s[N-1:W-1]) & ~(&quot_s[N-1:W-1]);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = MUL;
            MUL:  state_nxt = DIV;
            // Leaving on an idle divider as well keeps the FSM from ever
            // stranding in DIV.
            DIV:  if (div_done || !div_busy) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            out_p   <= '0;
            out_ovf <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_q <= in_a;
                b_q <= in_b;
            end
            // A zero product is treated as positive so it never becomes -0
            // or picks the negative saturation limit.
            if (state == MUL) begin
                neg_q <= (a_q[W-1] ^ b_q[W-1]) && (prod != '0);
            end
            if (state == FIX) begin
                out_ovf <= ovf;
                if (SAT != 0 && ovf) begin
                    out_p <= neg_q ? P_MIN : P_MAX;
                end else begin
                    out_p <= quot_s[W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_fx_mul_scale.sv
// Directed self-checking bench for fx_mul_scale.
// Three instances: W=16/SCALE=100/SAT=1 (sel 0), W=16/SCALE=100/SAT=0 (sel 1), W=8/SCALE=10/SAT=1 (sel 2).
// Expected values below are worked out by hand from (a*b)/SCALE truncated toward zero.
module tb_fx_mul_scale;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [2:0]  in_valid  = '0;
    logic [2:0]  out_ready = '0;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_ovf;

    logic [15:0] in_a0 = '0, in_b0 = '0, out_p0;
    logic [15:0] in_a1 = '0, in_b1 = '0, out_p1;
    logic [7:0]  in_a2 = '0, in_b2 = '0, out_p2;

    int n_checks = 0;
    int n_fail   = 0;

    int p, ovf, lat, stable;

    always #5 clk = ~clk;

    fx_mul_scale #(.W(16), .SCALE(100), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a0), .in_b(in_b0),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_p(out_p0), .out_ovf(out_ovf[0])
    );

    fx_mul_scale #(.W(16), .SCALE(100), .SAT(0)) dut_wrap (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a1), .in_b(in_b1),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_p(out_p1), .out_ovf(out_ovf[1])
    );

    fx_mul_scale #(.W(8), .SCALE(10), .SAT(1)) dut_w8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_a(in_a2), .in_b(in_b2),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_p(out_p2), .out_ovf(out_ovf[2])
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Present one operand pair to instance 'sel', then wait (bounded) for its
    // result. lat counts rising edges from the accept edge to out_valid.
    task automatic do_op(input int sel, input int a, input int b,
                         output int rp, output int rovf, output int rlat);
        int got;
        @(negedge clk);
        case (sel)
            0:       begin in_a0 = a[15:0]; in_b0 = b[15:0]; end
            1:       begin in_a1 = a[15:0]; in_b1 = b[15:0]; end
            default: begin in_a2 = a[7:0];  in_b2 = b[7:0];  end
        endcase
        in_valid[sel] = 1'b1;
        @(posedge clk);
        #1 in_valid[sel] = 1'b0;
        rlat = 0;
        got  = 0;
        while (got == 0 && rlat < 100) begin
            @(posedge clk);
            rlat++;
            @(negedge clk);
            if (out_valid[sel]) got = 1;
        end
        if (got == 0) check_eq("result_timeout", got, 1);
        case (sel)
            0:       rp = int'($signed(out_p0));
            1:       rp = int'($signed(out_p1));
            default: rp = int'($signed(out_p2));
        endcase
        rovf = int'(out_ovf[sel]);
    endtask

    task automatic ack(input int sel);
        @(negedge clk);
        out_ready[sel] = 1'b1;
        @(posedge clk);
        #1 out_ready[sel] = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        check_eq("rst_in_ready",  in_ready[0],  0);
        check_eq("rst_out_valid", out_valid[0], 0);
        check_eq("rst_out_p",     out_p0,       0);
        check_eq("rst_out_ovf",   out_ovf[0],   0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_in_ready", in_ready[0], 1);

        // -9306*99 = -921294 -> /100 -> -9212
        do_op(0, -9306, 99, p, ovf, lat);
        check_eq("neg_p",   p,   -9212);
        check_eq("neg_ovf", ovf, 0);
        check_eq("neg_lat", lat, 34);
        ack(0);

        // 32767^2/100 = 10736762 -> saturates positive
        do_op(0, 32767, 32767, p, ovf, lat);
        check_eq("satpos_p",   p,   32767);
        check_eq("satpos_ovf", ovf, 1);
        ack(0);

        // -32768*32767/100 = -10737090 -> saturates negative
        do_op(0, -32768, 32767, p, ovf, lat);
        check_eq("satneg_p",   p,   -32768);
        check_eq("satneg_ovf", ovf, 1);
        ack(0);

        // Wrap: 10736762 = 0xA3D47A -> low 16 bits 0xD47A = -11142
        do_op(1, 32767, 32767, p, ovf, lat);
        check_eq("wrap_p",   p,   -11142);
        check_eq("wrap_ovf", ovf, 1);
        check_eq("wrap_lat", lat, 34);
        ack(1);

        // Backpressure: 150*-7 = -1050 -> -10 (toward zero)
        do_op(0, 150, -7, p, ovf, lat);
        check_eq("bp_p",   p,   -10);
        check_eq("bp_lat", lat, 34);
        stable = 1;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid[0] || $signed(out_p0) != -16'sd10 || in_ready[0]) stable = 0;
        end
        check_eq("bp_stable", stable, 1);
        ack(0);
        @(negedge clk);
        check_eq("bp_in_ready_after", in_ready[0],  1);
        check_eq("bp_valid_after",    out_valid[0], 0);

        // Zero operand
        do_op(0, 0, -5, p, ovf, lat);
        check_eq("zero_p",   p,   0);
        check_eq("zero_ovf", ovf, 0);
        ack(0);

        // Reset mid-DIV: accept, wait 10 edges, then reset
        @(negedge clk);
        in_a0 = 16'd1000;
        in_b0 = 16'd1000;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("midrst_valid",    out_valid[0], 0);
        check_eq("midrst_in_ready", in_ready[0],  0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("postrst_in_ready", in_ready[0], 1);
        check_eq("postrst_valid",    out_valid[0], 0);
        do_op(0, 200, 300, p, ovf, lat);
        check_eq("postrst_p",   p,   600);
        check_eq("postrst_ovf", ovf, 0);
        check_eq("postrst_lat", lat, 34);
        ack(0);

        // W=8, SCALE=10: 16384/10 = 1638 -> 127 saturated; -75/10 -> -7
        do_op(2, -128, -128, p, ovf, lat);
        check_eq("w8_sat_p",   p,   127);
        check_eq("w8_sat_ovf", ovf, 1);
        check_eq("w8_lat",     lat, 18);
        ack(2);
        do_op(2, 25, -3, p, ovf, lat);
        check_eq("w8_neg_p",   p,   -7);
        check_eq("w8_neg_ovf", ovf, 0);
        ack(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
